// File: rtl/cpu_run_controller.sv
// Run/check sequencer for the single-cycle core: pulses the core's reset at a start PC,
// runs until the PC leaves the program, captures MemtoRegOut and reports pass/fail/timeout.
module cpu_run_controller #(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int HOLD_CYCLES = 1,
   parameter int WDOG_W      = 16
) (
   input  logic              CLK,
   input  logic              resetl,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_pc,
   input  logic [ADDR_W-1:0] end_pc,
   input  logic [DATA_W-1:0] expected,
   output logic              cpu_reset,
   output logic [ADDR_W-1:0] cpu_startpc,
   input  logic [ADDR_W-1:0] cpu_currentpc,
   input  logic [DATA_W-1:0] cpu_memtoreg,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              pass,
   output logic              timeout,
   output logic [WDOG_W-1:0] cycle_count
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   // The edge that would bring the watchdog to all-ones is the one that ends the run.
   localparam logic [WDOG_W-1:0] WDOG_TRIP = {WDOG_W{1'b1}} - WDOG_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_HOLD,
      S_SYNC,
      S_RUN,
      S_FINISH
   } state_t;

   function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
      return (v == {WDOG_W{1'b1}}) ? v : v + WDOG_W'(1);
   endfunction

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic [ADDR_W-1:0]   start_pc_q, start_pc_d;
   logic [ADDR_W-1:0]   end_pc_q, end_pc_d;
   logic [DATA_W-1:0]   expected_q, expected_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                pass_q, pass_d;
   logic                timeout_q, timeout_d;
   logic [WDOG_W-1:0]   cycle_q, cycle_d;

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q    <= S_IDLE;
         hold_q     <= '0;
         wdog_q     <= '0;
         start_pc_q <= '0;
         end_pc_q   <= '0;
         expected_q <= '0;
         result_q   <= '0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         cycle_q    <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         wdog_q     <= wdog_d;
         start_pc_q <= start_pc_d;
         end_pc_q   <= end_pc_d;
         expected_q <= expected_d;
         result_q   <= result_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         cycle_q    <= cycle_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      wdog_d     = wdog_q;
      start_pc_d = start_pc_q;
      end_pc_d   = end_pc_q;
      expected_d = expected_q;
      result_d   = result_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      cycle_d    = cycle_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_pc_d = start_pc;
               end_pc_d   = end_pc;
               expected_d = expected;
               result_d   = '0;
               pass_d     = 1'b0;
               timeout_d  = 1'b0;
               cycle_d    = '0;
               wdog_d     = '0;
               hold_d     = '0;
               state_d    = S_RST_HOLD;
            end
         end
         S_RST_HOLD: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (hold_q == HOLD_LAST) begin
               state_d = S_SYNC;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_SYNC: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (cpu_currentpc == start_pc_q) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (cpu_currentpc < end_pc_q) begin
               result_d = cpu_memtoreg;
               cycle_d  = sat_inc(cycle_q);
            end else begin
               pass_d  = (result_q == expected_q);
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Watchdog expiry wins over whatever the active state wanted to do this edge.
      if ((state_q inside {S_RST_HOLD, S_SYNC, S_RUN}) && (wdog_q == WDOG_TRIP)) begin
         state_d   = S_FINISH;
         timeout_d = 1'b1;
         pass_d    = 1'b0;
         result_d  = result_q;
         cycle_d   = cycle_q;
      end
   end

   // Core is held in reset whenever it is not being synchronised or run.
   assign cpu_reset   = (state_q != S_SYNC) && (state_q != S_RUN);
   assign cpu_startpc = start_pc_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FINISH);
   assign result      = result_q;
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign cycle_count = cycle_q;

endmodule
